i2c_cond_gen: RTL and testbench
===============================

# i2c_cond_gen

Parametrised I2C bus-condition generator: produces START, repeated-START and STOP conditions on open-drain SDA/SCL drive lines. It supports slave clock stretching and reports bus errors. It sits between the I2C master sequencer and the pad/open-drain layer, sharing the bus with the byte engine. Drive outputs are 1 = released (pulled high) and 0 = pulled low.

## Interface
- CLK_FREQ, 25_000_000, system clock in Hz
- I2C_FREQ, 100_000, SCL frequency in Hz; quarter period Q = CLK_FREQ/(4*I2C_FREQ), integer division, elaboration error if Q < 2
- STRETCH_MAX, 4096, max cycles SCL may be held low by a slave (used only with I2C_STRETCH_TIMEOUT_EN)
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  request; accepted when i_req & o_ready and i_cmd valid
- i_cmd  in  2  0=START, 1=RESTART, 2=STOP, 3=reserved (never accepted)
- o_ready  out  1  high only in IDLE
- o_done  out  1  one-cycle pulse, condition completed successfully
- o_err  out  1  one-cycle pulse, condition aborted
- o_err_code  out  2  0=none, 1=BUSY, 2=STRETCH_TO, 3=SDA_STUCK; valid with o_err, held until next accept
- i_sda, i_scl  in  1 each  bus levels, already synchronised upstream
- o_sda_drive, o_scl_drive  out  1 each  line drives

## Operation
- Reset values: o_sda_drive=1, o_scl_drive=1, o_ready=1, o_done=0, o_err=0, o_err_code=0. Reset mid-condition releases both lines immediately (asynchronously).
- Accept cycle A: latch cmd, check preconditions. On failure, issue a BUSY error; the lines are not touched.
  - START requires i_scl=1 and i_sda=1.
  - RESTART and STOP require i_scl=0.
- Every timed phase lasts exactly Q cycles, counted by a down-counter. Drives change on the first cycle of the phase.
- START: SDA low for 2Q, then SCL low for Q, then DONE.
- RESTART: SDA released (SCL still low) for Q. Then SCL released, entering STRETCH. Then SCL high for Q, SDA low for Q, SCL low for Q, then DONE.
- STOP: SDA low (SCL low) for Q. Then SCL released, entering STRETCH. Then SCL high for Q, SDA released for Q. At the end of the last cycle, if i_sda=0 the result is ERR(SDA_STUCK), otherwise DONE.
- STRETCH: drive SCL=1 and stay until i_scl is sampled 1; occupies at least 1 cycle. The following high phase starts in the next cycle.
- DONE and ERR each last one cycle (pulse), then return to IDLE.
- In ERR, both drives are 1.
- States: IDLE, SDA_LOW, SDA_HIGH, SCL_LOW, SCL_REL, STRETCH, SCL_HIGH, SDA_REL, DONE, ERR.
- i_req outside IDLE is ignored. Requests with cmd=3 are never accepted.

## Timing
- No stretch, accept at cycle A:
  - START: o_done at A+1+3Q.
  - RESTART: o_done at A+2+4Q.
  - STOP: o_done/o_err at A+2+3Q.
- o_ready returns high the cycle after o_done or o_err.
- Each stretch cycle beyond the first delays completion by exactly one cycle.
- BUSY error: o_err at A+1, o_ready again at A+2.
- o_done and o_err are never high together.

## Configuration
- I2C_STRETCH_TIMEOUT_EN defined: a counter runs in STRETCH. After STRETCH_MAX cycles with i_scl=0, the block enters ERR(STRETCH_TO) and releases both lines.
- Macro not defined: STRETCH waits indefinitely, the STRETCH_TO code is never produced, and no counter is synthesised.

## Structure
- i2c_pkg: t_i2c_cmd enum, t_i2c_err enum, t_cond_state enum, and a function computing Q from CLK_FREQ and I2C_FREQ. These are shared with the byte engine.
- One sub-module, i2c_phase_timer: loadable down-counter with load, terminal-count and busy outputs, width $clog2(2Q+1).
- Control state lives in a single packed struct register with next-state combinational logic.

## Test plan
Bench uses CLK_FREQ=25_000_000 and I2C_FREQ=100_000, so Q=62.
- START on an idle bus (sda=scl=1) at A=10: o_sda_drive falls at 11; o_scl_drive falls at 135; o_done pulses at 197; o_ready is back at 198.
- STOP from scl=0, no stretch: SCL released at A+63, SDA released at A+126, o_done at A+188; a model SDA returns high.
- RESTART with the slave holding SCL low 20 extra cycles: o_done at A+2+248+20; SDA falls only after SCL has been high for 62 cycles.
- START while i_sda=0: o_err at A+1 with o_err_code=1; drives stay 1.
- STOP with the model holding SDA low: o_err with code 3 at A+188; no o_done.
- With I2C_STRETCH_TIMEOUT_EN and STRETCH_MAX=100, SCL stuck low: o_err code 2 exactly 100 cycles after entering STRETCH. Async reset asserted mid-START releases both drives in the same cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command, error and condition-state encodings plus
// the quarter-period helper. Also used by the byte engine.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START   = 2'd0,
    CMD_RESTART = 2'd1,
    CMD_STOP    = 2'd2,
    CMD_RSVD    = 2'd3
  } t_i2c_cmd;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BUSY       = 2'd1,
    ERR_STRETCH_TO = 2'd2,
    ERR_SDA_STUCK  = 2'd3
  } t_i2c_err;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SDA_LOW,
    ST_SDA_HIGH,
    ST_SCL_LOW,
    ST_SCL_REL,
    ST_STRETCH,
    ST_SCL_HIGH,
    ST_SDA_REL,
    ST_DONE,
    ST_ERR
  } t_cond_state;

  // Quarter SCL period in system clock cycles (integer division).
  function automatic int unsigned calc_quarter(input int unsigned clk_freq,
                                               input int unsigned i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_cond_gen_if.sv
// Request/response and open-drain line bundle of the condition generator.
//   master : sequencer + pad side (drives request, command, bus levels)
//   slave  : the condition generator itself
interface i2c_cond_gen_if;
  import i2c_pkg::*;

  logic     i_req;
  t_i2c_cmd i_cmd;
  logic     o_ready;
  logic     o_done;
  logic     o_err;
  t_i2c_err o_err_code;
  logic     i_sda;
  logic     i_scl;
  logic     o_sda_drive;
  logic     o_scl_drive;

  modport master (
    output i_req, i_cmd, i_sda, i_scl,
    input  o_ready, o_done, o_err, o_err_code, o_sda_drive, o_scl_drive
  );

  modport slave (
    input  i_req, i_cmd, i_sda, i_scl,
    output o_ready, o_done, o_err, o_err_code, o_sda_drive, o_scl_drive
  );

endinterface

// File: rtl/i2c_phase_timer.sv
// Loadable down-counter timing one bus phase.
//   i_clk, i_rst     : clock, async active-high reset
//   i_load/i_load_val: start a phase of i_load_val cycles
//   o_tc_c           : last cycle of the running phase
//   o_busy_c         : a phase is running
module i2c_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc_c,
  output logic         o_busy_c
);

  logic [W-1:0] cnt;

  // Count reaches 1 on the last cycle of a phase, then parks at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign o_tc_c   = (cnt == W'(1));
  assign o_busy_c = (cnt != '0);

endmodule

// File: rtl/i2c_cond_gen.sv
// I2C START / repeated-START / STOP generator with clock-stretch support.
//   i_clk, i_rst : clock, async active-high reset (releases both lines)
//   bus          : request/status handshake and open-drain SDA/SCL lines
// Optional: I2C_STRETCH_TIMEOUT_EN bounds clock stretching to STRETCH_MAX
// cycles and reports STRETCH_TO.
module i2c_cond_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned I2C_FREQ    = 100_000,
  parameter int unsigned STRETCH_MAX = 4096
) (
  input logic           i_clk,
  input logic           i_rst,
  i2c_cond_gen_if.slave bus
);

  localparam int unsigned Q  = calc_quarter(CLK_FREQ, I2C_FREQ);
  localparam int unsigned TW = $clog2(2 * Q + 1);
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int unsigned SW = $clog2(STRETCH_MAX + 1);
`endif

  if (Q < 2) begin : g_bad_q
    $error("i2c_cond_gen: quarter period below 2 clock cycles");
  end
  if (STRETCH_MAX < 1) begin : g_bad_stretch
    $error("i2c_cond_gen: STRETCH_MAX must be at least 1");
  end

  typedef struct packed {
    t_cond_state state;
    t_i2c_cmd    cmd;
    logic        sda_drive;
    logic        scl_drive;
    logic        ready;
    logic        done;
    logic        err;
    t_i2c_err    err_code;
`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [SW-1:0] stretch_cnt;
`endif
  } ctl_t;

  ctl_t          r;
  ctl_t          n;
  logic          tmr_load_c;
  logic [TW-1:0] tmr_val_c;
  logic          tmr_tc_c;
  logic          tmr_busy_c;
  logic          phase_end_c;
  logic          pre_ok_c;

  i2c_phase_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load_c),
    .i_load_val (tmr_val_c),
    .o_tc_c     (tmr_tc_c),
    .o_busy_c   (tmr_busy_c)
  );

  assign phase_end_c = tmr_busy_c & tmr_tc_c;

  // START needs an idle bus; RESTART/STOP need SCL already low.
  assign pre_ok_c = (bus.i_cmd == CMD_START) ? (bus.i_scl & bus.i_sda) : ~bus.i_scl;

  // Control register; reset releases both lines at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r           <= '0;
      r.state     <= ST_IDLE;
      r.sda_drive <= 1'b1;
      r.scl_drive <= 1'b1;
      r.ready     <= 1'b1;
      r.err_code  <= ERR_NONE;
    end else begin
      r <= n;
    end
  end

  // Next control state; drives are set on the transition into each phase.
  always_comb begin
    n          = r;
    tmr_load_c = 1'b0;
    tmr_val_c  = TW'(Q);
`ifdef I2C_STRETCH_TIMEOUT_EN
    n.stretch_cnt = '0;
`endif
    case (r.state)
      ST_IDLE: begin
        if (bus.i_req && (bus.i_cmd != CMD_RSVD)) begin
          n.cmd      = bus.i_cmd;
          n.err_code = ERR_NONE;
          tmr_load_c = 1'b1;
          if (!pre_ok_c) begin
            // Lines are left exactly as they were.
            n.state    = ST_ERR;
            n.err_code = ERR_BUSY;
          end else begin
            case (bus.i_cmd)
              CMD_START: begin
                n.state     = ST_SDA_LOW;
                n.sda_drive = 1'b0;
                tmr_val_c   = TW'(2 * Q);
              end
              CMD_RESTART: begin
                n.state     = ST_SDA_HIGH;
                n.sda_drive = 1'b1;
                n.scl_drive = 1'b0;
              end
              default: begin
                n.state     = ST_SDA_LOW;
                n.sda_drive = 1'b0;
                n.scl_drive = 1'b0;
              end
            endcase
          end
        end
      end
      ST_SDA_LOW: begin
        if (phase_end_c) begin
          if (r.cmd == CMD_STOP) begin
            n.state     = ST_SCL_REL;
            n.scl_drive = 1'b1;
          end else begin
            n.state     = ST_SCL_LOW;
            n.scl_drive = 1'b0;
            tmr_load_c  = 1'b1;
          end
        end
      end
      ST_SDA_HIGH: begin
        if (phase_end_c) begin
          n.state     = ST_SCL_REL;
          n.scl_drive = 1'b1;
        end
      end
      // SCL_REL is the first cycle of a possible stretch; STRETCH the rest.
      ST_SCL_REL, ST_STRETCH: begin
        if (bus.i_scl) begin
          n.state    = ST_SCL_HIGH;
          tmr_load_c = 1'b1;
        end else begin
          n.state = ST_STRETCH;
`ifdef I2C_STRETCH_TIMEOUT_EN
          n.stretch_cnt = r.stretch_cnt + SW'(1);
          if (r.stretch_cnt == SW'(STRETCH_MAX - 1)) begin
            n.state     = ST_ERR;
            n.err_code  = ERR_STRETCH_TO;
            n.sda_drive = 1'b1;
            n.scl_drive = 1'b1;
          end
`endif
        end
      end
      ST_SCL_HIGH: begin
        if (phase_end_c) begin
          tmr_load_c  = 1'b1;
          n.state     = (r.cmd == CMD_STOP) ? ST_SDA_REL : ST_SDA_LOW;
          n.sda_drive = (r.cmd == CMD_STOP);
        end
      end
      ST_SDA_REL: begin
        if (phase_end_c) begin
          if (bus.i_sda) begin
            n.state = ST_DONE;
          end else begin
            n.state    = ST_ERR;
            n.err_code = ERR_SDA_STUCK;
          end
        end
      end
      ST_SCL_LOW: begin
        if (phase_end_c) begin
          n.state = ST_DONE;
        end
      end
      default: begin
        n.state = ST_IDLE;
      end
    endcase
    n.ready = (n.state == ST_IDLE);
    n.done  = (n.state == ST_DONE);
    n.err   = (n.state == ST_ERR);
  end

  assign bus.o_ready     = r.ready;
  assign bus.o_done      = r.done;
  assign bus.o_err       = r.err;
  assign bus.o_err_code  = r.err_code;
  assign bus.o_sda_drive = r.sda_drive;
  assign bus.o_scl_drive = r.scl_drive;

endmodule

// File: tb/tb_i2c_cond_gen.sv
// Self-checking bench for i2c_cond_gen: directed and randomized conditions
// against a phase-list timeline model with a reactive slave on SDA/SCL.
module tb_i2c_cond_gen;
  import i2c_pkg::*;

  localparam int unsigned CLK_FREQ    = 25_000_000;
  localparam int unsigned I2C_FREQ    = 100_000;
  localparam int unsigned STRETCH_MAX = 100;
  localparam int          Q           = int'(CLK_FREQ / (4 * I2C_FREQ));

  logic clk = 1'b0;
  logic rst;
  logic slave_sda;
  logic slave_scl;
  int   stretch_left;
  int   n_chk = 0;
  int   n_err = 0;

  // Model view of the line drives and the last reported error code.
  logic       m_sda;
  logic       m_scl;
  logic [1:0] m_code;
  logic [6:0] exp_q[$];

  i2c_cond_gen_if bus();

  assign bus.i_sda = bus.o_sda_drive & slave_sda;
  assign bus.i_scl = bus.o_scl_drive & slave_scl;

  i2c_cond_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .I2C_FREQ    (I2C_FREQ),
    .STRETCH_MAX (STRETCH_MAX)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] mk(input logic sda, input logic scl, input logic rdy,
                                    input logic dn, input logic er, input logic [1:0] code);
    return {sda, scl, rdy, dn, er, code};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.o_sda_drive, bus.o_scl_drive, bus.o_ready, bus.o_done, bus.o_err,
            2'(bus.o_err_code)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sda, input logic scl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(sda, scl, 1'b0, 1'b0, 1'b0, 2'd0));
  endtask

  task automatic idle(input int n);
    bus.i_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check("idle", 32'(obs()), 32'(mk(m_sda, m_scl, 1'b1, 1'b0, 1'b0, m_code)));
    end
  endtask

  task automatic try_reserved(input int n);
    bus.i_req = 1'b1;
    bus.i_cmd = CMD_RSVD;
    for (int i = 0; i < n; i++) begin
      step();
      check("rsvd", 32'(obs()), 32'(mk(m_sda, m_scl, 1'b1, 1'b0, 1'b0, m_code)));
    end
    bus.i_req = 1'b0;
  endtask

  // Build the expected per-cycle timeline from phase lengths, then run it.
  task automatic run_cond(input t_i2c_cmd cmd, input int extra, input logic sda_hold,
                          input string tag);
    logic ok;
    logic timeout;
    exp_q.delete();
    slave_sda    = ~sda_hold;
    stretch_left = (cmd == CMD_START) ? 0 : extra;
    slave_scl    = (stretch_left == 0);
    if (cmd == CMD_START) ok = m_sda & slave_sda & m_scl & slave_scl;
    else                  ok = ~(m_scl & slave_scl);
`ifdef I2C_STRETCH_TIMEOUT_EN
    timeout = (extra >= int'(STRETCH_MAX));
`else
    timeout = 1'b0;
`endif
    if (!ok) begin
      m_code = 2'd1;
      exp_q.push_back(mk(m_sda, m_scl, 1'b0, 1'b0, 1'b1, 2'd1));
    end else begin
      m_code = 2'd0;
      if (cmd == CMD_START) begin
        push(1'b0, m_scl, 2 * Q);
        push(1'b0, 1'b0, Q);
        m_sda = 1'b0;
        m_scl = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
      end else begin
        // RESTART releases SDA first; STOP pulls it low first.
        push(cmd == CMD_RESTART, 1'b0, Q);
        if (timeout) begin
          push(cmd == CMD_RESTART, 1'b1, int'(STRETCH_MAX));
          m_code = 2'd2;
          m_sda  = 1'b1;
          m_scl  = 1'b1;
          exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2));
        end else if (cmd == CMD_RESTART) begin
          push(1'b1, 1'b1, extra + 1);
          push(1'b1, 1'b1, Q);
          push(1'b0, 1'b1, Q);
          push(1'b0, 1'b0, Q);
          m_sda = 1'b0;
          m_scl = 1'b0;
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
        end else begin
          push(1'b0, 1'b1, extra + 1);
          push(1'b0, 1'b1, Q);
          push(1'b1, 1'b1, Q);
          m_sda = 1'b1;
          m_scl = 1'b1;
          if (sda_hold) begin
            m_code = 2'd3;
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3));
          end else begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
          end
        end
      end
    end
    exp_q.push_back(mk(m_sda, m_scl, 1'b1, 1'b0, 1'b0, m_code));

    bus.i_req = 1'b1;
    bus.i_cmd = cmd;
    foreach (exp_q[i]) begin
      step();
      check($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(exp_q[i]));
      // Slave keeps SCL low for 'extra' cycles after the master releases it.
      slave_scl = (stretch_left == 0);
      if (bus.o_scl_drive && (stretch_left > 0)) stretch_left--;
      // Requests while busy must be ignored.
      bus.i_req = exp_q[i][4] ? 1'b0 : 1'($urandom_range(0, 1));
      bus.i_cmd = t_i2c_cmd'($urandom_range(0, 3));
    end
    bus.i_req    = 1'b0;
    stretch_left = 0;
    slave_scl    = 1'b1;
    slave_sda    = 1'b1;
  endtask

  initial begin
    int   c;
    int   ex;
    logic hold;
    rst          = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_cmd    = CMD_START;
    slave_sda    = 1'b1;
    slave_scl    = 1'b1;
    stretch_left = 0;
    m_sda        = 1'b1;
    m_scl        = 1'b1;
    m_code       = 2'd0;

    repeat (3) step();
    check("reset_vec", 32'(obs()), 32'(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0)));
    rst = 1'b0;
    step();
    check("reset_done", 32'(bus.o_done), 32'd0);
    check("reset_err", 32'(bus.o_err), 32'd0);
    idle(5);

    run_cond(CMD_START, 0, 1'b0, "start");
    run_cond(CMD_STOP, 0, 1'b0, "stop");
    run_cond(CMD_START, 0, 1'b1, "start_busy");
    run_cond(CMD_RESTART, 0, 1'b0, "restart_busy");
    run_cond(CMD_STOP, 0, 1'b0, "stop_busy");
    try_reserved(4);
    idle(2);
    run_cond(CMD_START, 0, 1'b0, "start2");
    run_cond(CMD_RESTART, 20, 1'b0, "restart_str20");
    run_cond(CMD_STOP, 0, 1'b1, "stop_stuck");
    idle(3);
    run_cond(CMD_START, 0, 1'b0, "start3");
    run_cond(CMD_RESTART, int'(STRETCH_MAX) - 1, 1'b0, "restart_str_max_m1");
    run_cond(CMD_STOP, int'(STRETCH_MAX), 1'b0, "stop_str_max");
    run_cond(CMD_START, 0, 1'b0, "start4");
    run_cond(CMD_RESTART, 150, 1'b0, "restart_str150");
    idle(2);

    for (int it = 0; it < 40; it++) begin
      c  = int'($urandom_range(0, 3));
      ex = 0;
      if (c == 3) begin
        try_reserved(int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 2) == 0) ex = int'($urandom_range(1, 30));
`ifdef I2C_STRETCH_TIMEOUT_EN
        if ($urandom_range(0, 7) == 0) ex = int'($urandom_range(95, 110));
`endif
        hold = ($urandom_range(0, 5) == 0);
        run_cond(t_i2c_cmd'(2'(c)), ex, hold, "rnd");
        idle(int'($urandom_range(0, 2)));
      end
    end

    // Asynchronous reset in the middle of a START.
    if (!m_scl) run_cond(CMD_STOP, 0, 1'b0, "stop_pre_rst");
    bus.i_req = 1'b1;
    bus.i_cmd = CMD_START;
    step();
    bus.i_req = 1'b0;
    repeat (40) step();
    check("pre_rst_sda", 32'(bus.o_sda_drive), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sda", 32'(bus.o_sda_drive), 32'd1);
    check("async_rst_scl", 32'(bus.o_scl_drive), 32'd1);
    check("async_rst_rdy", 32'(bus.o_ready), 32'd1);
    step();
    rst    = 1'b0;
    m_sda  = 1'b1;
    m_scl  = 1'b1;
    m_code = 2'd0;
    idle(3);
    run_cond(CMD_START, 0, 1'b0, "start_post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
